// File: rtl/trail_gen.sv
// trail_gen -- scrolling player trail generator.
//
// Keeps a ring of 41 trail entries. On every game tick that is not a pause,
// active entries move left by SCROLL_STEP and are retired when they would
// pass x=0. While playing, a new entry is emitted every EMIT_PERIOD ticks at
// (PLAYER_X, player_y) with full life. The oldest entry is overwritten once
// the ring wraps.
//
// Optional feature: define TRAIL_FADE_EN to make entries lose one life
// point every LIFE_DIV ticks. Without it, life stays 15 until scroll-off.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset, overrides tick
//   tick         one-cycle game-frame enable
//   gamemode     00 idle (clear), 01 playing, 10 paused, 11 game over
//   player_y     current player y coordinate
//   trail_x      41 x 10-bit packed entry x (entry i at [i*10 +: 10])
//   trail_y      41 x 9-bit packed entry y
//   trail_life   41 x 4-bit packed entry life, 0 = inactive
//   active_count number of entries with nonzero life
module trail_gen #(
    parameter logic [9:0]  PLAYER_X    = 10'd100,
    parameter int unsigned SCROLL_STEP = 4,
    parameter int unsigned EMIT_PERIOD = 2,
    parameter int unsigned LIFE_DIV    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [1:0]   gamemode,
    input  logic [8:0]   player_y,
    output logic [409:0] trail_x,
    output logic [368:0] trail_y,
    output logic [163:0] trail_life,
    output logic [5:0]   active_count
);

    localparam int unsigned N = 41;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    localparam logic [9:0] STEP = 10'(SCROLL_STEP);

    if (SCROLL_STEP == 0 || EMIT_PERIOD == 0 || LIFE_DIV == 0) begin : g_bad_cfg
        $error("trail_gen: SCROLL_STEP, EMIT_PERIOD and LIFE_DIV must be nonzero");
    end

    logic [9:0]  x_q    [N];
    logic [9:0]  x_d    [N];
    logic [8:0]  y_q    [N];
    logic [8:0]  y_d    [N];
    logic [3:0]  life_q [N];
    logic [3:0]  life_d [N];
    logic [5:0]  wp_q, wp_d;
    logic [15:0] emit_q, emit_d;
    logic [5:0]  count_d;
    logic        emit_now;
`ifdef TRAIL_FADE_EN
    logic [15:0] div_q, div_d;
    logic        decay;
`endif

    always_comb begin
        wp_d     = wp_q;
        emit_d   = emit_q;
        emit_now = 1'b0;
`ifdef TRAIL_FADE_EN
        div_d    = div_q;
        decay    = 1'b0;
`endif
        for (int unsigned i = 0; i < N; i++) begin
            x_d[i]    = x_q[i];
            y_d[i]    = y_q[i];
            life_d[i] = life_q[i];
        end

        if (tick) begin
            case (gamemode)
                MODE_IDLE: begin
                    wp_d   = '0;
                    emit_d = '0;
`ifdef TRAIL_FADE_EN
                    div_d  = '0;
`endif
                    for (int unsigned i = 0; i < N; i++) begin
                        x_d[i]    = '0;
                        y_d[i]    = '0;
                        life_d[i] = '0;
                    end
                end
                MODE_PLAY, MODE_OVER: begin
`ifdef TRAIL_FADE_EN
                    decay = (div_q == 16'(LIFE_DIV - 1));
                    div_d = decay ? '0 : div_q + 16'd1;
`endif
                    if (gamemode == MODE_PLAY) begin
                        emit_now = (emit_q == '0);
                        emit_d   = (emit_q == 16'(EMIT_PERIOD - 1)) ? '0 : emit_q + 16'd1;
                        if (emit_now)
                            wp_d = (wp_q == 6'(N - 1)) ? '0 : wp_q + 6'd1;
                    end
                    for (int unsigned i = 0; i < N; i++) begin
                        // A fresh write wins over scroll/decay of the same slot,
                        // and replaces whatever lived there (oldest discarded).
                        if (emit_now && wp_q == 6'(i)) begin
                            x_d[i]    = PLAYER_X;
                            y_d[i]    = player_y;
                            life_d[i] = 4'd15;
                        end else if (life_q[i] != '0) begin
                            // Retire rather than wrap below x=0; x is left as-is.
                            if (x_q[i] < STEP) begin
                                life_d[i] = '0;
                            end else begin
                                x_d[i] = x_q[i] - STEP;
`ifdef TRAIL_FADE_EN
                                // life is nonzero here, so no underflow.
                                if (decay)
                                    life_d[i] = life_q[i] - 4'd1;
`endif
                            end
                        end
                    end
                end
                default: ; // paused: full freeze
            endcase
        end

        count_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (life_d[i] != '0)
                count_d = count_d + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            emit_q       <= '0;
`ifdef TRAIL_FADE_EN
            div_q        <= '0;
`endif
            active_count <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                life_q[i] <= '0;
            end
        end else begin
            wp_q         <= wp_d;
            emit_q       <= emit_d;
`ifdef TRAIL_FADE_EN
            div_q        <= div_d;
`endif
            active_count <= count_d;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
                life_q[i] <= life_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            trail_x[i*10 +: 10]   = x_q[i];
            trail_y[i*9 +: 9]     = y_q[i];
            trail_life[i*4 +: 4]  = life_q[i];
        end
    end

endmodule

// File: tb/tb_trail_gen.sv
// tb_trail_gen -- directed self-checking bench for trail_gen.
// Three instances share stimulus: defaults (PLAYER_X=100), PLAYER_X=400 for
// wrap/decay, PLAYER_X=11 so an entry lands exactly on x=3 for scroll-off.
module tb_trail_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic [1:0]   gamemode = 2'b00;
    logic [8:0]   player_y = '0;

    logic [409:0] x_a, x_w, x_s;
    logic [368:0] y_a, y_w, y_s;
    logic [163:0] l_a, l_w, l_s;
    logic [5:0]   c_a, c_w, c_s;

    logic [409:0] snap_x;
    logic [368:0] snap_y;
    logic [163:0] snap_l;
    logic [5:0]   snap_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trail_gen dut (
        .clk(clk), .rst(rst), .tick(tick), .gamemode(gamemode), .player_y(player_y),
        .trail_x(x_a), .trail_y(y_a), .trail_life(l_a), .active_count(c_a)
    );

    trail_gen #(.PLAYER_X(10'd400)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .gamemode(gamemode), .player_y(player_y),
        .trail_x(x_w), .trail_y(y_w), .trail_life(l_w), .active_count(c_w)
    );

    trail_gen #(.PLAYER_X(10'd11)) dut_s (
        .clk(clk), .rst(rst), .tick(tick), .gamemode(gamemode), .player_y(player_y),
        .trail_x(x_s), .trail_y(y_s), .trail_life(l_s), .active_count(c_s)
    );

    function automatic logic [9:0] ex(input logic [409:0] v, input int i);
        return v[i*10 +: 10];
    endfunction
    function automatic logic [8:0] ey(input logic [368:0] v, input int i);
        return v[i*9 +: 9];
    endfunction
    function automatic logic [3:0] el(input logic [163:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    task automatic check(input string tag, input logic [409:0] obs, input logic [409:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on negedge; outputs are sampled on negedge after the tick edge.
    task automatic do_tick(input logic [1:0] mode, input logic [8:0] py);
        @(negedge clk);
        tick = 1'b1; gamemode = mode; player_y = py;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b1; gamemode = 2'b01;
        @(negedge clk);
        rst = 1'b0; tick = 1'b0;
    endtask

    initial begin
        // Reset with tick high
        do_reset();
        check("rst_x", x_a, '0);
        check("rst_y", y_a, '0);
        check("rst_life", l_a, '0);
        check("rst_count", c_a, '0);

        // Emit and scroll: 3 ticks playing at y=240
        do_tick(2'b01, 9'd240);
        do_tick(2'b01, 9'd240);
        do_tick(2'b01, 9'd240);
        check("e0_x", ex(x_a, 0), 10'd92);
        check("e0_y", ey(y_a, 0), 9'd240);
        check("e1_x", ex(x_a, 1), 10'd100);
        check("e1_life", el(l_a, 1), 4'd15);
`ifdef TRAIL_FADE_EN
        check("e0_life", el(l_a, 0), 4'd14);
`else
        check("e0_life", el(l_a, 0), 4'd15);
`endif
        check("e_count", c_a, 6'd2);

        snap_x = x_a; snap_y = y_a; snap_l = l_a; snap_c = c_a;

        // Mode changes between ticks have no effect
        @(negedge clk);
        gamemode = 2'b00;
        repeat (3) @(negedge clk);
        gamemode = 2'b01;
        @(negedge clk);
        check("hold_x", x_a, snap_x);
        check("hold_life", l_a, snap_l);

        // Pause for 10 ticks
        repeat (10) do_tick(2'b10, 9'd7);
        check("pause_x", x_a, snap_x);
        check("pause_y", y_a, snap_y);
        check("pause_life", l_a, snap_l);
        check("pause_count", c_a, snap_c);

        // Resume: tick 4 has no emit, tick 5 emits into entry 2
        do_tick(2'b01, 9'd50);
        check("res_e0_x", ex(x_a, 0), 10'd88);
        check("res_e1_x", ex(x_a, 1), 10'd96);
        check("res_e2_life", el(l_a, 2), 4'd0);
        do_tick(2'b01, 9'd51);
        check("res_e2_x", ex(x_a, 2), 10'd100);
        check("res_e2_y", ey(y_a, 2), 9'd51);
        check("res_count", c_a, 6'd3);

        // Idle tick clears everything, then emission restarts at entry 0
        do_tick(2'b00, 9'd9);
        check("idle_x", x_a, '0);
        check("idle_y", y_a, '0);
        check("idle_life", l_a, '0);
        check("idle_count", c_a, 6'd0);
        do_tick(2'b01, 9'd17);
        check("idle_e0_x", ex(x_a, 0), 10'd100);
        check("idle_e0_y", ey(y_a, 0), 9'd17);
        check("idle_count2", c_a, 6'd1);

        // Scroll-off at x=3, and no emission in game-over mode
        do_reset();
        do_tick(2'b01, 9'd5);
        check("so_e0_x0", ex(x_s, 0), 10'd11);
        do_tick(2'b11, 9'd5);
        do_tick(2'b11, 9'd5);
        check("so_x3", ex(x_s, 0), 10'd3);
        check("so_count1", c_s, 6'd1);
        do_tick(2'b11, 9'd5);
        check("so_life", el(l_s, 0), 4'd0);
        check("so_x_kept", ex(x_s, 0), 10'd3);
        check("so_count0", c_s, 6'd0);
        check("over_noemit_count", c_a, 6'd1);
        check("over_e0_x", ex(x_a, 0), 10'd88);

`ifndef TRAIL_FADE_EN
        // Wrap: 84 ticks at PLAYER_X=400, player_y = tick number
        do_reset();
        for (int t = 1; t <= 84; t++) do_tick(2'b01, 9'(t));
        check("wrap_count", c_w, 6'd41);
        check("wrap_e0_x", ex(x_w, 0), 10'd396);
        check("wrap_e0_y", ey(y_w, 0), 9'd83);
        check("wrap_e1_x", ex(x_w, 1), 10'd76);
        check("wrap_e1_y", ey(y_w, 1), 9'd3);
        check("wrap_e40_x", ex(x_w, 40), 10'd388);
        do_tick(2'b01, 9'd85);
        check("wrap_e1_new_x", ex(x_w, 1), 10'd400);
        check("wrap_e1_new_y", ey(y_w, 1), 9'd85);
        check("wrap_count2", c_w, 6'd41);
`else
        // Decay: one emission, then game over until life runs out
        do_reset();
        do_tick(2'b01, 9'd20);
        for (int k = 1; k <= 43; k++) do_tick(2'b11, 9'd20);
        check("decay_life1", el(l_w, 0), 4'd1);
        check("decay_count1", c_w, 6'd1);
        do_tick(2'b11, 9'd20);
        check("decay_life0", el(l_w, 0), 4'd0);
        check("decay_count0", c_w, 6'd0);
        check("decay_x", ex(x_w, 0), 10'd224);
`endif

        // Reset mid-operation
        do_tick(2'b01, 9'd1);
        do_reset();
        check("rst2_life", l_a, '0);
        check("rst2_count", c_a, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
